// File: rtl/md_unit_pkg.sv
// Shared multiply/divide operation codes and FSM state encoding for the MD unit
// and the decoder that produces md_op.
package md_defs;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    function automatic logic isCompute(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic isDivide(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_calc.sv
// Combinational 64-bit product / quotient / remainder generator for the MD unit.
// wr_o is low when the result must not reach HI/LO (divide by zero).
module md_calc
    import md_defs::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        wr_o
);

    logic [63:0] prod;
    logic [31:0] divisor;

    // The divisor is forced non-zero so the dividers never see x; wr_o masks the result.
    always_comb begin
        prod    = 64'd0;
        divisor = (b_i == 32'd0) ? 32'd1 : b_i;
        hi_o    = 32'd0;
        lo_o    = 32'd0;
        wr_o    = 1'b0;
        case (op_i)
            MD_MULT: begin
                prod = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
                hi_o = prod[63:32];
                lo_o = prod[31:0];
                wr_o = 1'b1;
            end
            MD_MULTU: begin
                prod = {32'd0, a_i} * {32'd0, b_i};
                hi_o = prod[63:32];
                lo_o = prod[31:0];
                wr_o = 1'b1;
            end
            MD_DIV: begin
                wr_o = (b_i != 32'd0);
                if (a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
                    lo_o = 32'h8000_0000;
                    hi_o = 32'd0;
                end else begin
                    lo_o = $signed(a_i) / $signed(divisor);
                    hi_o = $signed(a_i) % $signed(divisor);
                end
            end
            MD_DIVU: begin
                wr_o = (b_i != 32'd0);
                lo_o = a_i / divisor;
                hi_o = a_i % divisor;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs mult/div with a fixed busy
// latency and serves mfhi/mflo/mthi/mtlo. busy/start feed the D-stage stall logic.
module md_unit
    import md_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    md_state_e   state_q;
    logic [3:0]  count_q;
    logic        busy_q;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pendHi_q, pendHi_d;
    logic [31:0] pendLo_q, pendLo_d;
    logic        pendWr_q, pendWr_d;

    logic [31:0] calcHi, calcLo;
    logic        calcWr;
    logic        accept, idleEn, finish;

    md_calc u_calc (
        .op_i (md_op),
        .a_i  (src_a),
        .b_i  (src_b),
        .hi_o (calcHi),
        .lo_o (calcLo),
        .wr_o (calcWr)
    );

    assign start  = en & isCompute(md_op);
    assign idleEn = en & (state_q == IDLE);
    assign accept = start & (state_q == IDLE);
    assign finish = (state_q == BUSY) && (count_q == 4'd1);

    assign busy   = busy_q;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign md_out = (md_op == MD_MFHI) ? hi_q : lo_q;

    // Ops arriving while BUSY are ignored entirely: idleEn/accept gate every update.
    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        pendHi_d = pendHi_q;
        pendLo_d = pendLo_q;
        pendWr_d = pendWr_q;
        if (accept) begin
            pendHi_d = calcHi;
            pendLo_d = calcLo;
            pendWr_d = calcWr;
        end
        if (finish && pendWr_q) begin
            hi_d = pendHi_q;
            lo_d = pendLo_q;
        end else if (idleEn && md_op == MD_MTHI) begin
            hi_d = src_a;
        end else if (idleEn && md_op == MD_MTLO) begin
            lo_d = src_a;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            pendHi_q <= 32'd0;
            pendLo_q <= 32'd0;
            pendWr_q <= 1'b0;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            pendHi_q <= pendHi_d;
            pendLo_q <= pendLo_d;
            pendWr_q <= pendWr_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= 4'd0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= BUSY;
                        count_q <= isDivide(md_op) ? DIV_CNT : MULT_CNT;
                        busy_q  <= 1'b1;
                    end
                end
                BUSY: begin
                    count_q <= count_q - 4'd1;
                    if (count_q == 4'd1) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Randomized scoreboard bench for md_unit: completions are checked by a monitor
// against an arithmetic reference model; directed cases cover the listed corners.
module tb_md_unit;
    import md_defs::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  md_op;
    logic [31:0] src_a, src_b;
    logic        start, busy;
    logic [31:0] hi, lo, md_out;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        expQ[$];
    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] modelHi = 32'd0;
    logic [31:0] modelLo = 32'd0;
    int          busyRun = 0;
    logic        prevBusy = 1'b0;

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .md_op  (md_op),
        .src_a  (src_a),
        .src_b  (src_b),
        .start  (start),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .md_out (md_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference arithmetic done in 64-bit integers straight from the ISA definition.
    task automatic modelOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] rHi, output logic [31:0] rLo, output bit wr);
        longint sa, sb, q, r;
        longint unsigned p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        rHi = modelHi; rLo = modelLo; wr = 1'b1;
        case (op)
            MD_MULT:  begin q = sa * sb; rHi = q[63:32]; rLo = q[31:0]; end
            MD_MULTU: begin p = {32'd0, a} * {32'd0, b}; rHi = p[63:32]; rLo = p[31:0]; end
            MD_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; rLo = q[31:0]; rHi = r[31:0]; end
                      else wr = 1'b0;
            MD_DIVU:  if (b != 0) begin rLo = a / b; rHi = a % b; end
                      else wr = 1'b0;
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            expQ.delete();
            busyRun  = 0;
            prevBusy = 1'b0;
        end else begin
            if (busy) busyRun++;
            else if (prevBusy) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL completion: got unexpected busy drop, expected none");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("busyCycles", 32'(busyRun), 32'(e.cycles));
                    checkOutput("hi", hi, e.hi);
                    checkOutput("lo", lo, e.lo);
                end
                busyRun = 0;
            end
            prevBusy = busy;
        end
    end

    // Guard against stall-logic violations the bench itself might commit.
    always @(posedge clk) begin
        if (!reset && busy && en && md_op != MD_NONE)
            $error("[TB] MD op presented while busy");
    end

    task automatic waitIdle();
        int guard = 0;
        @(negedge clk);
        while ((busy || expQ.size() != 0) && guard < 40) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 40) begin
            checkCount++;
            $display("[TB] FAIL waitIdle: got busy after 40 cycles, expected idle");
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] rHi, rLo;
        bit wr;
        exp_t e;
        waitIdle();
        @(posedge clk); #1;
        en = 1'b1; md_op = op; src_a = a; src_b = b;
        #1;
        if (isCompute(op)) begin
            checkOutput("start", 32'(start), 32'd1);
            modelOp(op, a, b, rHi, rLo, wr);
            if (wr) begin modelHi = rHi; modelLo = rLo; end
            e.hi = modelHi; e.lo = modelLo;
            e.cycles = isDivide(op) ? DIV_N : MULT_N;
            expQ.push_back(e);
        end else if (op == MD_MTHI) modelHi = a;
        else if (op == MD_MTLO) modelLo = a;
        @(posedge clk); #1;
        en = 1'b0; md_op = MD_NONE;
    endtask

    task automatic readBack();
        waitIdle();
        #1;
        en = 1'b1; md_op = MD_MFHI; #1;
        checkOutput("mfhi", md_out, modelHi);
        md_op = MD_MFLO; #1;
        checkOutput("mflo", md_out, modelLo);
        en = 1'b0; md_op = MD_NONE;
    endtask

    initial begin
        int stalls, guard;
        logic [3:0] ops[6];
        ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO};

        reset = 1'b1; en = 1'b0; md_op = MD_NONE; src_a = '0; src_b = '0;
        #12;
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetHi", hi, 32'd0);
        checkOutput("resetLo", lo, 32'd0);
        checkOutput("resetMdOut", md_out, 32'd0);
        @(posedge clk); #3; reset = 1'b0;

        applyStimulus(MD_MULT,  32'hFFFF_FFFE, 32'd3);
        applyStimulus(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
        applyStimulus(MD_DIV,   32'hFFFF_FFF9, 32'd2);
        applyStimulus(MD_DIVU,  32'd7, 32'd2);
        applyStimulus(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        readBack();
        applyStimulus(MD_MTHI,  32'h11, 32'd0);
        applyStimulus(MD_MTLO,  32'h22, 32'd0);
        applyStimulus(MD_DIVU,  32'd99, 32'd0);
        readBack();

        waitIdle();
        @(posedge clk); #1;
        en = 1'b1; md_op = MD_MTHI; src_a = 32'h1234;
        @(posedge clk); #1;
        md_op = MD_MTLO; src_a = 32'h5678;
        @(posedge clk); #1;
        en = 1'b0; md_op = MD_NONE;
        modelHi = 32'h1234; modelLo = 32'h5678;
        checkOutput("mthiB2B", hi, 32'h1234);
        checkOutput("mtloB2B", lo, 32'h5678);
        readBack();

        // mult in E with mflo waiting in D: count the cycles D would stall.
        waitIdle();
        @(posedge clk); #1;
        en = 1'b1; md_op = MD_MULT; src_a = 32'd1000; src_b = 32'hFFFF_FFF0;
        applyPipeModel();
        #1;
        stalls = 0; guard = 0;
        while ((start || busy) && guard < 30) begin
            stalls++; guard++;
            @(posedge clk); #1;
            en = 1'b0; md_op = MD_NONE; #1;
        end
        checkOutput("pipeStalls", 32'(stalls), 32'(MULT_N + 1));
        en = 1'b1; md_op = MD_MFLO; #1;
        checkOutput("pipeMflo", md_out, modelLo);
        @(posedge clk); #1;
        en = 1'b0; md_op = MD_NONE;

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = $urandom();
            b = $urandom();
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'(int'($urandom_range(0, 7)) - 4);
                2: a = 32'h8000_0000;
                default: ;
            endcase
            applyStimulus(ops[$urandom_range(0, 5)], a, b);
            if (i % 4 == 3) readBack();
        end
        readBack();

        // Reset in the third busy cycle of a mult must abort it.
        applyStimulus(MD_MULT, 32'd12345, 32'd678);
        @(posedge clk); #3;
        reset = 1'b1; #1;
        checkOutput("midResetBusy", 32'(busy), 32'd0);
        checkOutput("midResetHi", hi, 32'd0);
        checkOutput("midResetLo", lo, 32'd0);
        modelHi = 32'd0; modelLo = 32'd0;
        @(posedge clk); #3; reset = 1'b0;
        repeat (12) @(posedge clk);
        checkOutput("postResetBusy", 32'(busy), 32'd0);
        readBack();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    task automatic applyPipeModel();
        logic [31:0] rHi, rLo;
        bit wr;
        exp_t e;
        modelOp(md_op, src_a, src_b, rHi, rLo, wr);
        modelHi = rHi; modelLo = rLo;
        e.hi = rHi; e.lo = rLo; e.cycles = MULT_N;
        expQ.push_back(e);
    endtask

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Execute-stage multiply/divide unit for the five-stage MIPS pipeline.
- Owns the HI/LO register pair. Implements mult, multu, div, divu, mfhi, mflo, mthi and mtlo with fixed multi-cycle latency.
- Sits beside the ALU between the D/E and E/M pipeline registers. Its busy/start outputs feed the D-stage stall logic.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- en  input  1  E-stage instruction is valid (not a bubble or flush)
- md_op  input  4  operation code (MD_* constants)
- src_a  input  32  forwarded rs value (SrcA_E)
- src_b  input  32  forwarded rt value (WriteData_E)
- start  output  1  combinational: en & md_op is one of MULT/MULTU/DIV/DIVU
- busy  output  1  registered: computation in progress
- hi  output  32  architectural HI
- lo  output  32  architectural LO
- md_out  output  32  combinational: hi when md_op==MFHI, else lo; goes into Result select via EM_REG

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE, count=0, busy=0, hi=0, lo=0, pending results=0.
  - The in-flight operation is discarded.
- States:
  - IDLE --(start & !busy)--> BUSY
  - BUSY --(count==1)--> IDLE
- Operation accepted at edge k (IDLE, en, start):
  - Compute the full result from src_a/src_b sampled at edge k and store it in pending_hi/pending_lo.
  - Load count = MULT_CYCLES or DIV_CYCLES.
  - Set busy=1.
- In BUSY, count decrements every edge. On the edge where count goes 1->0:
  - hi<=pending_hi, lo<=pending_lo.
  - busy<=0, state=IDLE.
- Net effect: busy is high for exactly N cycles after edge k. The new HI/LO is visible in the first cycle busy is low.
- Arithmetic:
  - mult: 64-bit signed product, {hi,lo}.
  - multu: 64-bit unsigned product, {hi,lo}.
  - div: signed, quotient truncates toward zero. lo=quotient, hi=remainder, with the remainder taking the dividend's sign.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - divu: unsigned, lo=quotient, hi=remainder.
  - Divide by zero (src_b==0): busy still asserts for DIV_CYCLES; hi/lo keep their previous values.
- mthi/mtlo (en, !busy): hi (resp. lo) <= src_a at the next edge, no busy.
- mfhi/mflo: purely combinational read of the current hi/lo. No state change.
- Any MD op presented while busy is a stall-logic violation:
  - Required: unit ignores it; state, count and pending values unchanged.
  - Bench asserts this never occurs in a legal pipeline.
- en=0 or md_op=MD_NONE: no effect.
- Hazard contract (implemented in the top-level stall logic, not here):
  - stall_md = D instr is any MD op & (start | busy).
  - stall_md ORs into the existing Stall, which freezes PC/FD and clears DE.

Decomposition:
- Shared package md_defs holds:
  - MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MFHI=5, MD_MFLO=6, MD_MTHI=7, MD_MTLO=8 (4-bit)
  - state encodings IDLE/BUSY
- The controller imports the same constants to decode funct 0x18/0x19/0x1A/0x1B/0x10/0x12/0x11/0x13.
- One sub-module is natural: md_calc, a combinational 64-bit product/quotient/remainder generator with the div special cases. The FSM, counter and HI/LO live in md_unit.

Test Plan:
- Reset then idle -> hi=0, lo=0, busy=0, md_out=0. Assert reset during busy at cycle 3 of a mult -> busy drops immediately, hi/lo=0.
- mult src_a=0xFFFFFFFE (-2), src_b=3 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div src_a=0xFFFFFFF9 (-7), src_b=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/2 -> lo=3, hi=1.
- div 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0. divu by 0 with hi=0x11, lo=0x22 -> busy 10 cycles, hi/lo unchanged.
- mthi 0x1234, mtlo 0x5678 on consecutive cycles -> hi=0x1234, lo=0x5678 one edge later. mfhi then mflo -> md_out 0x1234 then 0x5678.
- Full-pipeline: mult followed immediately by mflo -> D stalls for 6 cycles (start + 5 busy). mflo returns the new lo, and no instruction is lost or duplicated.
